instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, word-aligned PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is synchronous and active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address, equals PC.
REQ-006 imem_ack  input  1  memory accepts request; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  downstream not ready; hold current instruction.
REQ-009 branch_taken  input  1  redirect PC by branch_offset.
REQ-010 branch_offset  input  32  sign-extended 16-bit word offset (immediate after sign extension).
REQ-011 jump  input  1  redirect PC to jump target.
REQ-012 jump_target  input  26  instr_index field of J-type instruction.
REQ-013 instr  output  32  held instruction word.
REQ-014 imm16  output  16  instr[15:0], feeds the sign extender.
REQ-015 pc_out  output  32  PC of held instruction.
REQ-016 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-017 instr_valid  output  1  instr/pc_out/imm16 valid for consumption.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag (only with FETCH_TIMEOUT_EN).

Function
REQ-019 FSM states SHALL be IDLE, FETCH, VALID; encoding free.
REQ-020 IDLE SHALL transition to FETCH on the next clock unconditionally.
REQ-021 imem_req SHALL be 1 exactly when state is FETCH; imem_addr SHALL always equal pc_out.
REQ-022 In FETCH with imem_ack=1, instr SHALL load imem_rdata, instr_valid SHALL go 1 next cycle, state SHALL go VALID; imem_ack=0 holds FETCH.
REQ-023 imem_ack in IDLE or VALID SHALL be ignored.
REQ-024 In VALID with stall=1, all registers SHALL hold.
REQ-025 In VALID with stall=0, PC SHALL update and state SHALL go FETCH with instr_valid=0 next cycle; instr holds its last value.
REQ-026 Next PC: jump=1 -> {pc_plus4[31:28], jump_target, 2'b00}; else branch_taken=1 -> pc_plus4 + (branch_offset << 2); else pc_plus4.
REQ-027 jump SHALL take priority over branch_taken when both are 1.
REQ-028 All PC arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFFFFFC + 4 wraps to 32'h00000000; negative offsets subtract.
REQ-029 pc_out[1:0] SHALL always be 2'b00.
REQ-030 jump, branch_taken, branch_offset, jump_target SHALL be sampled only in VALID with stall=0.
REQ-031 imm16 SHALL be combinationally equal to instr[15:0].
REQ-032 Minimum instruction period SHALL be 2 cycles (FETCH with immediate ack, then VALID).

Reset
REQ-033 reset_n=0 at a rising edge SHALL set state=IDLE, pc_out=RESET_PC, instr=32'h00000000, instr_valid=0, fetch_err=0, timeout counter=0.
REQ-034 Reset SHALL override all other inputs in every state, including a simultaneous imem_ack in FETCH (word discarded).
REQ-035 imem_req SHALL be 0 in the first cycle after reset deassertion (IDLE).

Configuration
REQ-036 Macro FETCH_TIMEOUT_EN defined: 8-bit counter increments each FETCH cycle without ack, clears on entering FETCH.
REQ-037 With FETCH_TIMEOUT_EN, reaching 255 with no ack SHALL set fetch_err=1 (sticky until reset), load instr=32'h00000000 (NOP), go VALID.
REQ-038 FETCH_TIMEOUT_EN undefined: no counter, FETCH waits indefinitely, fetch_err tied to 0.

Verification
REQ-039 Reset with RESET_PC=32'h00400000, ack immediate -> imem_req 0 one cycle, then imem_addr=32'h00400000, instr_valid=1 two cycles after reset release.
REQ-040 Sequential fetch, stall=0 -> imem_addr sequence 00400000, 00400004, 00400008; imem_rdata 32'h2008FFFF gives imm16=16'hFFFF.
REQ-041 pc_out=32'h00400010, branch_taken=1, branch_offset=32'hFFFFFFFE -> next imem_addr=32'h0040000C; jump=1 also set, jump_target=26'h0100000 -> 32'h00400000 instead.
REQ-042 stall=1 for 5 cycles in VALID -> instr, pc_out unchanged, imem_req 0; PC at 32'hFFFFFFFC with stall=0 -> next 32'h00000000.
REQ-043 reset_n=0 same cycle as imem_ack in FETCH -> instr=0, instr_valid=0, state IDLE.
REQ-044 With FETCH_TIMEOUT_EN, ack withheld 255 cycles -> fetch_err=1, instr=0, instr_valid=1; without macro, imem_req stays 1.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC register, fetch FSM, held instruction; optional FETCH_TIMEOUT_EN
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    // Low address bits are forced clear so the PC stays word aligned whatever the parameter says.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] redirect_pc;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;
    logic        fetch_err_q, fetch_err_d;
`endif

    // Candidate next-PC values; jump wins over a taken branch, all arithmetic wraps at 32 bits.
    always_comb begin
        seq_pc      = pc_q + 32'd4;
        branch_pc   = seq_pc + (branch_offset << 2);
        jump_pc     = {seq_pc[31:28], jump_target, 2'b00};
        redirect_pc = seq_pc;
        if (jump) begin
            redirect_pc = jump_pc;
        end else if (branch_taken) begin
            redirect_pc = branch_pc;
        end
    end

    // Fetch FSM next-state and register updates; redirect inputs only matter when leaving VALID.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
                timeout_cnt_d = 8'd0;
`endif
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = VALID;
`ifdef FETCH_TIMEOUT_EN
                end else if (timeout_cnt_q == 8'd254) begin
                    // 255th unacknowledged cycle: give up and hand a NOP downstream.
                    timeout_cnt_d = 8'd255;
                    fetch_err_d   = 1'b1;
                    instr_d       = 32'h0000_0000;
                    instr_valid_d = 1'b1;
                    state_d       = VALID;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 8'd1;
`endif
                end
            end
            VALID: begin
                if (!stall) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
`ifdef FETCH_TIMEOUT_EN
                    timeout_cnt_d = 8'd0;
`endif
                end
            end
            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset overriding every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter and sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_cnt_q <= 8'd0;
            fetch_err_q   <= 1'b0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = seq_pc;
    assign instr       = instr_q;
    assign imm16       = instr_q[15:0];
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (table vectors, corner sequences, random vs model)
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;

    int passed = 0;
    int total  = 0;

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .instr(instr), .imm16(imm16), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        j;
        logic        b;
        logic [31:0] off;
        logic [25:0] tgt;
        logic [31:0] word;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC rule written as plain modular arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j, input logic b,
                                               input logic [31:0] off, input logic [25:0] tgt);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (j) return {p4[31:28], tgt, 2'b00};
        if (b) return p4 + off * 32'd4;
        return p4;
    endfunction

    // In FETCH: withhold ack for `delay` cycles, then return `word`; redirect inputs are toggled to prove they are ignored.
    task automatic serve(input logic [31:0] word, input int delay, input logic [31:0] exp_pc, input string tag);
        for (int i = 0; i < delay; i++) begin
            chk({tag, " wait req"}, {31'd0, imem_req}, 32'd1);
            chk({tag, " wait addr"}, imem_addr, exp_pc);
            imem_ack = 1'b0;
            jump = 1'b1;
            tick();
        end
        chk({tag, " req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, " addr"}, imem_addr, exp_pc);
        imem_ack = 1'b1;
        imem_rdata = word;
        jump = 1'b1;
        branch_taken = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        jump = 1'b0;
        branch_taken = 1'b0;
        chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, " instr"}, instr, word);
        chk({tag, " imm16"}, {16'd0, imm16}, {16'd0, word[15:0]});
        chk({tag, " pc_out"}, pc_out, exp_pc);
        chk({tag, " pc_plus4"}, pc_plus4, exp_pc + 32'd4);
        chk({tag, " req in valid"}, {31'd0, imem_req}, 32'd0);
    endtask

    // In VALID: release with the given redirect; the next cycle must be a fetch of exp_pc.
    task automatic release_to(input logic j, input logic b, input logic [31:0] off, input logic [25:0] tgt,
                              input logic [31:0] exp_pc, input string tag);
        stall = 1'b0;
        jump = j;
        branch_taken = b;
        branch_offset = off;
        jump_target = tgt;
        tick();
        stall = 1'b1;
        jump = 1'b0;
        branch_taken = 1'b0;
        chk({tag, " valid drop"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " next addr"}, imem_addr, exp_pc);
        chk({tag, " addr[1:0]"}, {30'd0, pc_out[1:0]}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [31:0] pc_m;
    logic [31:0] w;
    logic [31:0] held;
    logic        rj, rb;
    logic [31:0] roff;
    logic [25:0] rtgt;

    initial begin
        reset_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b1;
        branch_taken = 1'b0;
        branch_offset = 32'h0;
        jump = 1'b0;
        jump_target = 26'h0;

        vecs[0] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 26'h0100000, 32'h1111_0001, 32'h0040_0000};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 26'h3FFFFFF, 32'h2222_8002, 32'h0040_0004};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0003, 26'h3FFFFFF, 32'h3333_0003, 32'h0040_0014};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0000000, 32'h4444_0004, 32'h0040_0010};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0000000, 32'h5555_0005, 32'h0040_000C};
        vecs[5] = '{1'b0, 1'b1, 32'hFFEF_FFFB, 26'h0000000, 32'h6666_0006, 32'hFFFF_FFFC};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 26'h0000000, 32'h7777_0007, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 26'h3FFFFFF, 32'h8888_0008, 32'h0FFF_FFFC};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 26'h0000000, 32'h9999_0009, 32'h1000_0000};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_0100, 26'h0000001, 32'hAAAA_000A, 32'h1000_0004};

        // Reset state and first-fetch latency.
        tick();
        tick();
        chk("rst req", {31'd0, imem_req}, 32'd0);
        chk("rst pc", pc_out, RPC);
        chk("rst instr", instr, 32'h0);
        chk("rst valid", {31'd0, instr_valid}, 32'd0);
        chk("rst err", {31'd0, fetch_err}, 32'd0);
        reset_n = 1'b1;
        chk("idle req", {31'd0, imem_req}, 32'd0);
        tick();

        // Sequential fetches up to 0x00400010.
        serve(32'h2008_FFFF, 0, 32'h0040_0000, "seq0");
        release_to(1'b0, 1'b0, 32'h0, 26'h0, 32'h0040_0004, "seq0");
        serve(32'h0000_1234, 1, 32'h0040_0004, "seq1");
        release_to(1'b0, 1'b0, 32'h0, 26'h0, 32'h0040_0008, "seq1");
        serve(32'hDEAD_BEEF, 0, 32'h0040_0008, "seq2");
        release_to(1'b0, 1'b0, 32'h0, 26'h0, 32'h0040_000C, "seq2");
        serve(32'h0BAD_F00D, 2, 32'h0040_000C, "seq3");
        release_to(1'b0, 1'b0, 32'h0, 26'h0, 32'h0040_0010, "seq3");
        serve(32'h1234_5678, 0, 32'h0040_0010, "seq4");

        // Stall hold for 5 cycles with noisy redirect and stray ack.
        held = instr;
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            jump = 1'b1;
            branch_taken = 1'b1;
            imem_ack = 1'b1;
            imem_rdata = 32'hFFFF_0000;
            tick();
            chk("stall instr", instr, held);
            chk("stall pc", pc_out, 32'h0040_0010);
            chk("stall req", {31'd0, imem_req}, 32'd0);
            chk("stall valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;

        // Redirect table, each entry chained from the previous PC.
        for (int i = 0; i < 10; i++) begin
            release_to(vecs[i].j, vecs[i].b, vecs[i].off, vecs[i].tgt, vecs[i].exp_pc, $sformatf("vec%0d", i));
            serve(vecs[i].word, i % 3, vecs[i].exp_pc, $sformatf("vec%0d", i));
        end

        // Reset landing on the same edge as an ack: word discarded.
        release_to(1'b0, 1'b0, 32'h0, 26'h0, 32'h1000_0008, "pre-rst");
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_BABE;
        reset_n = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("rst+ack instr", instr, 32'h0);
        chk("rst+ack valid", {31'd0, instr_valid}, 32'd0);
        chk("rst+ack req", {31'd0, imem_req}, 32'd0);
        chk("rst+ack pc", pc_out, RPC);
        reset_n = 1'b1;
        tick();

        // Random stream against the model.
        pc_m = RPC;
        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            serve(w, int'($urandom_range(0, 3)), pc_m, "rnd");
            for (int s = int'($urandom_range(0, 2)); s > 0; s--) begin
                stall = 1'b1;
                jump = $urandom_range(0, 1) == 1;
                imem_ack = $urandom_range(0, 1) == 1;
                tick();
                chk("rnd hold instr", instr, w);
                chk("rnd hold pc", pc_out, pc_m);
            end
            imem_ack = 1'b0;
            rj = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 1) == 1);
            roff = ($urandom_range(0, 1) == 1) ? $urandom : {{16{1'b1}}, 16'($urandom)};
            rtgt = 26'($urandom);
            pc_m = model_next(pc_m, rj, rb, roff, rtgt);
            release_to(rj, rb, roff, rtgt, pc_m, "rnd");
        end

        // Fetch with ack withheld for 255 cycles.
        for (int i = 0; i < 255; i++) begin
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        chk("tmo err", {31'd0, fetch_err}, 32'd1);
        chk("tmo instr", instr, 32'h0);
        chk("tmo valid", {31'd0, instr_valid}, 32'd1);
        do_reset();
        chk("tmo err cleared", {31'd0, fetch_err}, 32'd0);
`else
        chk("no tmo req", {31'd0, imem_req}, 32'd1);
        chk("no tmo valid", {31'd0, instr_valid}, 32'd0);
        chk("no tmo err", {31'd0, fetch_err}, 32'd0);
        serve(32'h0000_00FF, 0, pc_m, "late ack");
        do_reset();
`endif
        chk("final idle req", {31'd0, imem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
